// File: rtl/jk_mod_counter_if.sv
// Control, data and status bundle for the jk_mod_counter bank.
// The master side drives mode/data; the slave (counter) returns state.
interface jk_mod_counter_if #(
    parameter int unsigned WIDTH = 4
);
    logic [1:0]       Mode;
    logic             Up;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] J;
    logic [WIDTH-1:0] K;
    logic [WIDTH-1:0] Q;
    logic             Tc;
    logic             Wrap;

    modport master (
        output Mode, Up, D, J, K,
        input  Q, Tc, Wrap
    );

    modport slave (
        input  Mode, Up, D, J, K,
        output Q, Tc, Wrap
    );
endinterface

// File: rtl/jk_mod_counter.sv
// WIDTH-bit bank of JK cells acting as a modulo-MODULUS up/down counter,
// saturating parallel-load register or raw JK bank, selected per cycle by Mode.
module jk_mod_counter #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 10
) (
    input  logic            Cp,
    input  logic            R,
    jk_mod_counter_if.slave bus
);
    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_COUNT = 2'b01,
        MODE_LOAD  = 2'b10,
        MODE_RAW   = 2'b11
    } mode_e;

    localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] LP_ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;

    mode_e            w_mode;
    logic             w_in_range;
    logic             w_term;
    logic             w_wrap_nxt;
    logic [WIDTH-1:0] w_step_val;
    logic [WIDTH-1:0] w_force_val;
    logic [WIDTH-1:0] w_load_val;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;

    assign w_mode      = mode_e'(bus.Mode);
    assign w_in_range  = (32'(r_q) < MODULUS);
    assign w_term      = bus.Up ? (r_q == LP_MAX) : (r_q == '0);
    assign w_step_val  = bus.Up ? (r_q + LP_ONE) : (r_q - LP_ONE);
    assign w_force_val = bus.Up ? '0 : LP_MAX;
    assign w_load_val  = (32'(bus.D) < MODULUS) ? bus.D : LP_MAX;

    // Every mode is expressed as J/K pairs: ordinary steps toggle the bits
    // that differ, while wrap, recovery and load use explicit set/clear pairs.
    always_comb begin
        w_j        = '0;
        w_k        = '0;
        w_wrap_nxt = 1'b0;
        case (w_mode)
            MODE_COUNT: begin
                if (!w_in_range) begin
                    w_j = w_force_val;
                    w_k = ~w_force_val;
                end else if (w_term) begin
                    w_j        = w_force_val;
                    w_k        = ~w_force_val;
                    w_wrap_nxt = 1'b1;
                end else begin
                    w_j = r_q ^ w_step_val;
                    w_k = r_q ^ w_step_val;
                end
            end
            MODE_LOAD: begin
                w_j = w_load_val;
                w_k = ~w_load_val;
            end
            MODE_RAW: begin
                w_j = bus.J;
                w_k = bus.K;
            end
            default: begin
                w_j = '0;
                w_k = '0;
            end
        endcase
    end

    always_ff @(posedge Cp or posedge R) begin
        if (R) begin
            r_q    <= '0;
            r_wrap <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                case ({w_j[i], w_k[i]})
                    2'b01:   r_q[i] <= 1'b0;
                    2'b10:   r_q[i] <= 1'b1;
                    2'b11:   r_q[i] <= ~r_q[i];
                    default: r_q[i] <= r_q[i];
                endcase
            end
            r_wrap <= w_wrap_nxt;
        end
    end

    assign bus.Q    = r_q;
    assign bus.Wrap = r_wrap;
    // Gated by R: Q is 0 during reset, which would otherwise flag a down-count terminal.
    assign bus.Tc   = ~R & (w_mode == MODE_COUNT) & w_term;
endmodule

// File: tb/tb_jk_mod_counter.sv
// Scoreboard bench for jk_mod_counter: a 4-bit modulo-10 instance and a
// 3-bit modulo-8 instance driven from hand-computed directed vectors.
module tb_jk_mod_counter;
    typedef struct {
        int         id;
        bit         sel;
        bit         cp;
        logic [3:0] epq;
        logic       epw;
        logic       etc;
        logic [3:0] eq;
        logic       ew;
    } item_t;

    logic Cp = 1'b0;
    logic R4 = 1'b1;
    logic R3 = 1'b1;

    item_t sb[$];
    int    errors  = 0;
    int    checks  = 0;
    int    step_id = 0;

    jk_mod_counter_if #(.WIDTH(4)) bus4 ();
    jk_mod_counter_if #(.WIDTH(3)) bus3 ();

    jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut4 (
        .Cp  (Cp),
        .R   (R4),
        .bus (bus4.slave)
    );

    jk_mod_counter #(.WIDTH(3), .MODULUS(8)) dut3 (
        .Cp  (Cp),
        .R   (R3),
        .bus (bus3.slave)
    );

    always #5 Cp = ~Cp;

    task automatic chk(input int id, input string nm, input logic [3:0] got, input logic [3:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL step%0d %s: got %0d want %0d", id, nm, got, want);
        end
    endtask

    // Inputs change on the falling edge; expected pre-edge Tc and post-edge Q/Wrap are queued.
    task automatic step(input bit sel, input logic r, input logic [1:0] m, input logic up,
                        input logic [3:0] d, input logic [3:0] j, input logic [3:0] k,
                        input logic etc, input logic [3:0] eq, input logic ew,
                        input bit cp = 1'b0, input logic [3:0] epq = 4'd0, input logic epw = 1'b0);
        item_t it;
        @(negedge Cp);
        if (sel) begin
            R3 = r; bus3.Mode = m; bus3.Up = up;
            bus3.D = d[2:0]; bus3.J = j[2:0]; bus3.K = k[2:0];
            bus4.Mode = 2'b00;
        end else begin
            R4 = r; bus4.Mode = m; bus4.Up = up;
            bus4.D = d; bus4.J = j; bus4.K = k;
            bus3.Mode = 2'b00;
        end
        step_id++;
        it.id = step_id; it.sel = sel; it.cp = cp; it.epq = epq; it.epw = epw;
        it.etc = etc; it.eq = eq; it.ew = ew;
        sb.push_back(it);
    endtask

    initial begin : monitor
        item_t      it;
        logic [3:0] pq, q;
        logic       pw, ptc, w;
        forever begin
            @(negedge Cp);
            #2;
            if (sb.size() != 0) begin
                it = sb[0];
                if (it.sel) begin
                    pq = {1'b0, bus3.Q}; pw = bus3.Wrap; ptc = bus3.Tc;
                end else begin
                    pq = bus4.Q; pw = bus4.Wrap; ptc = bus4.Tc;
                end
                @(posedge Cp);
                #1;
                if (it.sel) begin
                    q = {1'b0, bus3.Q}; w = bus3.Wrap;
                end else begin
                    q = bus4.Q; w = bus4.Wrap;
                end
                it = sb.pop_front();
                if (it.cp) begin
                    chk(it.id, "q_async", pq, it.epq);
                    chk(it.id, "wrap_async", {3'b0, pw}, {3'b0, it.epw});
                end
                chk(it.id, "tc", {3'b0, ptc}, {3'b0, it.etc});
                chk(it.id, "q", q, it.eq);
                chk(it.id, "wrap", {3'b0, w}, {3'b0, it.ew});
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int dn[8] = '{6, 5, 4, 3, 2, 1, 0, 9};
        bus4.Mode = 2'b00; bus4.Up = 1'b0; bus4.D = '0; bus4.J = '0; bus4.K = '0;
        bus3.Mode = 2'b00; bus3.Up = 1'b0; bus3.D = '0; bus3.J = '0; bus3.K = '0;

        // reset state; Tc held low under reset even with Mode=01, Up=0, Q=0
        step(0, 1, 2'b01, 0, 4'd0, 4'd0, 4'd0, 0, 4'd0, 0, 1, 4'd0, 0);
        step(1, 0, 2'b00, 0, 4'd0, 4'd0, 4'd0, 0, 4'd0, 0);

        // count up 12 edges from 0
        for (int i = 1; i <= 12; i++)
            step(0, 0, 2'b01, 1, 4'd0, 4'd0, 4'd0, (i == 10), 4'(i % 10), (i == 10));
        for (int i = 3; i <= 7; i++)
            step(0, 0, 2'b01, 1, 4'd0, 4'd0, 4'd0, 0, 4'(i), 0);
        // async reset at Q=7, then first edge counts normally
        step(0, 1, 2'b01, 1, 4'd0, 4'd0, 4'd0, 0, 4'd0, 0, 1, 4'd0, 0);
        step(0, 0, 2'b01, 1, 4'd0, 4'd0, 4'd0, 0, 4'd1, 0);

        // load 7, count down through wrap, reverse at Q=9
        step(0, 0, 2'b10, 0, 4'd7, 4'd0, 4'd0, 0, 4'd7, 0);
        for (int i = 0; i < 8; i++)
            step(0, 0, 2'b01, 0, 4'd0, 4'd0, 4'd0, (i == 7), 4'(dn[i]), (i == 7));
        step(0, 0, 2'b01, 1, 4'd0, 4'd0, 4'd0, 1, 4'd0, 1);
        // reset while Wrap=1 must clear it before the next edge
        step(0, 1, 2'b01, 1, 4'd0, 4'd0, 4'd0, 0, 4'd0, 0, 1, 4'd0, 0);
        step(0, 0, 2'b00, 0, 4'd0, 4'd0, 4'd0, 0, 4'd0, 0);

        // load saturation
        step(0, 0, 2'b10, 0, 4'd12, 4'd0, 4'd0, 0, 4'd9, 0);
        step(0, 0, 2'b10, 0, 4'd15, 4'd0, 4'd0, 0, 4'd9, 0);
        step(0, 0, 2'b01, 1, 4'd0, 4'd0, 4'd0, 1, 4'd0, 1);
        step(0, 0, 2'b10, 0, 4'd12, 4'd0, 4'd0, 0, 4'd9, 0);
        step(0, 0, 2'b10, 0, 4'd3, 4'd0, 4'd0, 0, 4'd3, 0);
        step(0, 1'b0, 2'b10, 1, 4'd9, 4'd0, 4'd0, 0, 4'd9, 0);
        step(0, 0, 2'b00, 1, 4'd0, 4'd0, 4'd0, 0, 4'd9, 0);

        // raw JK and out-of-range recovery
        step(0, 0, 2'b10, 0, 4'd0, 4'd0, 4'd0, 0, 4'd0, 0);
        step(0, 0, 2'b11, 0, 4'd0, 4'b1010, 4'b0101, 0, 4'd10, 0);
        step(0, 0, 2'b11, 0, 4'd0, 4'b1111, 4'b1111, 0, 4'd5, 0);
        step(0, 0, 2'b11, 0, 4'd0, 4'b0000, 4'b0000, 0, 4'd5, 0);
        step(0, 0, 2'b11, 0, 4'd0, 4'b1100, 4'b0011, 0, 4'd12, 0);
        step(0, 0, 2'b01, 1, 4'd0, 4'd0, 4'd0, 0, 4'd0, 0);
        step(0, 0, 2'b11, 0, 4'd0, 4'b1100, 4'b0011, 0, 4'd12, 0);
        step(0, 0, 2'b01, 0, 4'd0, 4'd0, 4'd0, 0, 4'd9, 0);
        step(0, 0, 2'b11, 1, 4'd0, 4'b0000, 4'b0000, 0, 4'd9, 0);
        step(0, 0, 2'b11, 0, 4'd0, 4'b1010, 4'b0101, 0, 4'd10, 0);
        step(0, 0, 2'b01, 1, 4'd0, 4'd0, 4'd0, 0, 4'd0, 0);
        step(0, 0, 2'b11, 0, 4'd0, 4'b1111, 4'b1111, 0, 4'd15, 0);
        step(0, 0, 2'b01, 0, 4'd0, 4'd0, 4'd0, 0, 4'd9, 0);

        // WIDTH=3, MODULUS=8 instance
        step(1, 0, 2'b10, 0, 4'd7, 4'd0, 4'd0, 0, 4'd7, 0);
        step(1, 0, 2'b01, 1, 4'd0, 4'd0, 4'd0, 1, 4'd0, 1);
        for (int i = 0; i < 3; i++)
            step(1, 0, 2'b00, 1, 4'd0, 4'd0, 4'd0, 0, 4'd0, 0);
        step(1, 0, 2'b01, 0, 4'd0, 4'd0, 4'd0, 1, 4'd7, 1);
        step(1, 0, 2'b01, 1, 4'd0, 4'd0, 4'd0, 1, 4'd0, 1);
        step(1, 0, 2'b10, 0, 4'd5, 4'd0, 4'd0, 0, 4'd5, 0);

        repeat (3) @(negedge Cp);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
